// File: rtl/stack_arb_pkg.sv
// Shared types and defaults for the two-requester stack arbiter.
// Holds the FSM state encoding, the push/pop op encoding and the size defaults.
package stack_arb_pkg;

    localparam int DEPTH_DEF = 128;
    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        POP  = 1'b0,
        PUSH = 1'b1
    } op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; combinational grant, pointer advances when i_adv is high.
// No backpressure: the caller decides when a grant is taken via i_adv.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    // Set when requester 1 took the last grant; reset so requester 0 wins first.
    logic r_last;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (i_adv) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two push/pop requesters onto one Stack; grant to ack is 2 cycles (3 per op).
// stall freezes the FSM and masks strobes/acks; flush drops the in-flight op without ack.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req0_valid,
    input  logic                       req1_valid,
    input  logic                       req0_push,
    input  logic                       req1_push,
    input  logic [WIDTH-1:0]           req0_d,
    input  logic [WIDTH-1:0]           req1_d,
    output logic                       req0_ack,
    output logic                       req1_ack,
    output logic [WIDTH-1:0]           req_q,
    output logic                       req_err,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           stack_d,
    output logic                       stack_push,
    output logic                       stack_pop,
    output logic                       stack_hold,
    output logic                       stack_reset,
    input  logic [WIDTH-1:0]           stack_q,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH+1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    op_t              r_op;
    logic [WIDTH-1:0] r_d;
    logic             r_gnt1;
    logic             r_push;
    logic             r_pop;
    logic             r_refused;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_stack_reset;

    logic [1:0]       w_gnt;
    logic             w_adv;
    op_t              w_op;
    logic [WIDTH-1:0] w_d;
    logic             w_full;
    logic             w_empty;
    logic             w_issue_go;
    logic             w_ack_any;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   ({req1_valid, req0_valid}),
        .i_adv   (w_adv),
        .o_gnt   (w_gnt)
    );

    assign w_op       = op_t'(w_gnt[1] ? req1_push : req0_push);
    assign w_d        = w_gnt[1] ? req1_d : req0_d;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_issue_go = (r_state == ISSUE) && !stall && !flush;

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else if (!stall) begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        w_state_nxt = ISSUE;
                        w_adv       = 1'b1;
                    end
                end
                ISSUE:   w_state_nxt = RESP;
                RESP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_op          <= POP;
            r_d           <= '0;
            r_gnt1        <= 1'b0;
            r_push        <= 1'b0;
            r_pop         <= 1'b0;
            r_refused     <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_stack_reset <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_stack_reset <= flush;
            // Legality is decided at grant: count cannot move again before ISSUE.
            if (w_adv) begin
                r_gnt1    <= w_gnt[1];
                r_op      <= w_op;
                r_d       <= w_d;
                r_push    <= (w_op == PUSH) && !w_full;
                r_pop     <= (w_op == POP) && !w_empty;
                r_refused <= (w_op == PUSH) ? w_full : w_empty;
            end
            if (flush) begin
                r_count <= '0;
                r_push  <= 1'b0;
                r_pop   <= 1'b0;
                r_ack0  <= 1'b0;
                r_ack1  <= 1'b0;
            end else if (w_issue_go) begin
                if (r_push) begin
                    r_count <= r_count + CW'(1);
                end else if (r_pop) begin
                    r_count <= r_count - CW'(1);
                end
                r_push <= 1'b0;
                r_pop  <= 1'b0;
                r_ack0 <= !r_gnt1;
                r_ack1 <= r_gnt1;
            end else if ((r_state == RESP) && !stall) begin
                r_ack0 <= 1'b0;
                r_ack1 <= 1'b0;
            end
            if (w_issue_go && r_refused && (r_op == PUSH)) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_issue_go && r_refused && (r_op == POP)) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Registered strobes and acks are masked in the cycle a stall or flush arrives.
    assign req0_ack    = r_ack0 && !stall && !flush;
    assign req1_ack    = r_ack1 && !stall && !flush;
    assign w_ack_any   = req0_ack || req1_ack;
    assign req_err     = w_ack_any && r_refused;
    assign req_q       = (w_ack_any && (r_op == POP) && !r_refused) ? stack_q : '0;
    assign stack_d     = r_d;
    assign stack_push  = r_push && !stall && !flush;
    assign stack_pop   = r_pop && !stall && !flush;
    assign stack_hold  = stall;
    assign stack_reset = r_stack_reset;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural Stack attached.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_stack_arbiter;
    import stack_arb_pkg::*;

    localparam int DEPTH = 128;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_push = 1'b0, req1_push = 1'b0;
    logic [WIDTH-1:0] req0_d = '0, req1_d = '0;
    logic             req0_ack, req1_ack, req_err;
    logic [WIDTH-1:0] req_q;
    logic             stall = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] stack_d;
    logic             stack_push, stack_pop, stack_hold, stack_reset;
    logic [WIDTH-1:0] stack_q = '0;
    logic [CW-1:0]    count;
    logic             full, empty, overflow, underflow;

    stack_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_push(req0_push), .req1_push(req1_push),
        .req0_d(req0_d), .req1_d(req1_d),
        .req0_ack(req0_ack), .req1_ack(req1_ack),
        .req_q(req_q), .req_err(req_err),
        .stall(stall), .flush(flush), .err_clr(err_clr),
        .stack_d(stack_d), .stack_push(stack_push), .stack_pop(stack_pop),
        .stack_hold(stack_hold), .stack_reset(stack_reset), .stack_q(stack_q),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural Stack with a registered output.
    logic [WIDTH-1:0] mem [DEPTH];
    int sp = 0;
    always @(posedge clk) begin
        if (stack_reset) begin
            sp <= 0;
        end else if (!stack_hold) begin
            if (stack_push && sp < DEPTH) begin
                mem[sp] <= stack_d;
                sp      <= sp + 1;
            end else if (stack_pop && sp > 0) begin
                stack_q <= mem[sp-1];
                sp      <= sp - 1;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    bit               op_acked;
    int               op_ack_cyc, op_push_cyc, op_pop_cyc;
    logic [WIDTH-1:0] op_q;
    logic             op_err, op_ovf, op_unf, op_full;
    logic [CW-1:0]    op_cnt;

    task automatic do_reset;
        reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Called 1ns after a rising edge; returns 1ns after the edge following the ack.
    task automatic do_op(input int who, input bit push, input logic [WIDTH-1:0] d);
        op_acked = 0; op_ack_cyc = -1; op_push_cyc = -1; op_pop_cyc = -1;
        op_q = '0; op_err = 1'b0;
        if (who == 0) begin
            req0_valid = 1'b1; req0_push = push; req0_d = d;
        end else begin
            req1_valid = 1'b1; req1_push = push; req1_d = d;
        end
        for (int c = 0; c < 20 && !op_acked; c++) begin
            @(negedge clk);
            if (stack_push && op_push_cyc < 0) op_push_cyc = c;
            if (stack_pop && op_pop_cyc < 0) op_pop_cyc = c;
            if ((who == 0 && req0_ack) || (who == 1 && req1_ack)) begin
                op_acked = 1; op_ack_cyc = c; op_q = req_q; op_err = req_err;
                op_ovf = overflow; op_unf = underflow; op_full = full; op_cnt = count;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int               seq [4];
    int               found;
    logic             hold_all, strobe_any, ack_any, pop6, hold6;
    logic [CW-1:0]    cnt_mid;
    logic [WIDTH-1:0] got_q;
    logic             got_err, got_unf;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_eq("rst_flags",
                  {req0_ack, req1_ack, req_err, overflow, underflow, stack_push, stack_pop, stack_reset, empty, full},
                  10'b0000000110);
        expect_eq("rst_count", count, 0);
        expect_eq("rst_data", {req_q, stack_d}, 64'h0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Single push: strobe in cycle 1, ack in cycle 2
        do_op(0, 1'b1, 32'hDEADBEEF);
        expect_eq("push1_acked", op_acked, 1);
        expect_eq("push1_strobe_cyc", op_push_cyc, 1);
        expect_eq("push1_ack_cyc", op_ack_cyc, 2);
        expect_eq("push1_err", op_err, 0);
        expect_eq("push1_count", op_cnt, 1);

        // Both pushing continuously from reset: grants alternate starting with 0
        do_reset();
        req0_valid = 1'b1; req0_push = 1'b1; req0_d = 32'hA0;
        req1_valid = 1'b1; req1_push = 1'b1; req1_d = 32'hB1;
        for (int k = 0; k < 4; k++) begin
            found = -1;
            for (int c = 0; c < 20 && found < 0; c++) begin
                @(negedge clk);
                if (req0_ack) found = 0;
                else if (req1_ack) found = 1;
            end
            seq[k] = found;
        end
        cnt_mid = count;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        expect_eq("rr_grant0", seq[0], 0);
        expect_eq("rr_grant1", seq[1], 1);
        expect_eq("rr_grant2", seq[2], 0);
        expect_eq("rr_grant3", seq[3], 1);
        expect_eq("rr_count", cnt_mid, 4);

        // LIFO order and underflow
        do_reset();
        do_op(0, 1'b1, 32'h11);
        do_op(1, 1'b1, 32'h22);
        do_op(0, 1'b0, 32'h0);
        expect_eq("pop1_q", op_q, 32'h22);
        do_op(1, 1'b0, 32'h0);
        expect_eq("pop2_q", op_q, 32'h11);
        expect_eq("pop2_count", op_cnt, 0);
        do_op(0, 1'b0, 32'h0);
        expect_eq("unf_acked", op_acked, 1);
        expect_eq("unf_err", op_err, 1);
        expect_eq("unf_flag", op_unf, 1);
        expect_eq("unf_q", op_q, 32'h0);
        expect_eq("unf_no_pop", op_pop_cyc < 0, 1);
        @(negedge clk);
        expect_eq("unf_sticky", underflow, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        expect_eq("unf_cleared", underflow, 0);
        @(posedge clk); #1;

        // Fill to DEPTH then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_op(i & 1, 1'b1, WIDTH'(i));
        end
        @(negedge clk);
        expect_eq("fill_count_full", {full, 8'(count)}, {1'b1, 8'd128});
        @(posedge clk); #1;
        do_op(0, 1'b1, 32'h55);
        expect_eq("ovf_acked", op_acked, 1);
        expect_eq("ovf_err", op_err, 1);
        expect_eq("ovf_flag", op_ovf, 1);
        expect_eq("ovf_full", op_full, 1);
        expect_eq("ovf_count", op_cnt, 128);
        expect_eq("ovf_no_push", op_push_cyc < 0, 1);

        // Stall held 5 cycles during ISSUE of a pop
        do_reset();
        do_op(0, 1'b1, 32'h77);
        req1_valid = 1'b1; req1_push = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 stall = 1'b1;
        hold_all = 1'b1; strobe_any = 1'b0; ack_any = 1'b0; cnt_mid = '0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            hold_all   = hold_all & stack_hold;
            strobe_any = strobe_any | stack_pop | stack_push;
            ack_any    = ack_any | req0_ack | req1_ack;
            if (s == 4) cnt_mid = count;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        found = -1; got_q = '0; got_err = 1'b1; pop6 = 1'b0; hold6 = 1'b1;
        for (int c = 0; c < 20 && found < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                pop6 = stack_pop; hold6 = stack_hold;
            end
            if (req1_ack) begin
                found = c; got_q = req_q; got_err = req_err;
            end
        end
        req1_valid = 1'b0;
        @(posedge clk); #1;
        expect_eq("stall_hold", hold_all, 1);
        expect_eq("stall_no_strobe", strobe_any, 0);
        expect_eq("stall_no_ack", ack_any, 0);
        expect_eq("stall_count_frozen", cnt_mid, 1);
        expect_eq("stall_release_pop", {pop6, hold6}, 2'b10);
        expect_eq("stall_ack_cyc", found, 1);
        expect_eq("stall_q", {got_err, got_q}, {1'b0, 32'h77});

        // Flush during RESP of the third push; held pop is re-served and refused
        do_reset();
        do_op(0, 1'b1, 32'hA);
        do_op(1, 1'b1, 32'hB);
        req0_valid = 1'b1; req0_push = 1'b1; req0_d = 32'hC;
        req1_valid = 1'b1; req1_push = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        expect_eq("fl_push_strobe", stack_push, 1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        expect_eq("fl_resp_count", count, 3);
        expect_eq("fl_no_ack", {req0_ack, req1_ack}, 2'b00);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        expect_eq("fl_stack_reset", stack_reset, 1);
        expect_eq("fl_count", count, 0);
        found = -1; got_q = '1; got_err = 1'b0; got_unf = 1'b0;
        for (int c = 0; c < 20 && found < 0; c++) begin
            @(negedge clk);
            if (req0_ack) found = 0;
            else if (req1_ack) begin
                found = 1; got_q = req_q; got_err = req_err; got_unf = underflow;
            end
        end
        req1_valid = 1'b0;
        expect_eq("fl_reserve_who", found, 1);
        expect_eq("fl_reserve_resp", {got_unf, got_err, got_q}, {2'b11, 32'h0});
        found = -1;
        for (int c = 0; c < 20 && found < 0; c++) begin
            @(negedge clk);
            if (req0_ack) begin
                found = 0; cnt_mid = count; got_err = req_err;
            end
        end
        req0_valid = 1'b0;
        expect_eq("fl_push_reserved", {found == 0, got_err, 8'(cnt_mid)}, {1'b1, 1'b0, 8'd1});
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
